pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
Duty-cycle sequencer that sits in front of pwm8 and drives its duty_in/duty_we pair. It accepts a fade command (target duty, step size, frames per step) over a valid/ready handshake. It then ramps the PWM duty toward the target, one step per N PWM frames, using the frame_tick pulse from the PWM frame edge. It supports instant jumps and aborts, and signals completion with a one-cycle done pulse.

Parameters:
WIDTH, 8, duty width; must match the pwm8 WIDTH.
DIV_W, 8, width of the frames-per-step divider.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
frame_tick  in  1  one-cycle pulse per PWM frame (PWM counter == all-ones).
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_target  in  WIDTH  target duty.
cmd_step  in  WIDTH  step magnitude; 0 = immediate jump.
cmd_div  in  DIV_W  frames per step minus 1; 0 = every frame.
abort  in  1  cancel the fade in progress.
duty_out  out  WIDTH  duty value to pwm8 duty_in.
duty_we  out  1  one-cycle write strobe to pwm8 duty_we.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset (rst high at a posedge): state=IDLE, cur=0, duty_out=0, duty_we=0, done=0, busy=0, frame counter=0. cmd_ready=0 while rst is high.
- The cur register holds the last duty written. duty_out always equals cur (registered).
- States: IDLE, WAIT, STEP, DONE.
- cmd_ready = (state==IDLE) && !rst. It is combinational; no other output is combinational.
- IDLE, on accept at cycle T: latch tgt, stp, div. Next state at T+1:
  - tgt==cur -> DONE (no write, regardless of stp).
  - else stp==0 -> STEP (jump).
  - else -> WAIT with frame counter cleared.
- WAIT:
  - Counts frame_tick pulses starting in the cycle after WAIT is entered.
  - When the count reaches div+1, next state is STEP.
  - frame_tick is ignored outside WAIT.
- STEP (exactly one cycle):
  - Compute nxt in WIDTH+1-bit arithmetic:
    - cur<tgt: nxt=min(cur+stp, tgt).
    - cur>tgt: nxt=max(cur-stp, tgt).
    - stp==0: nxt=tgt.
  - Never overshoots and never wraps: 250+10 toward 255 gives 255; 5-10 toward 0 gives 0.
  - Registered outputs: cur<=nxt, duty_out<=nxt, duty_we<=1 for one cycle. duty_we is therefore visible the cycle after STEP.
  - Next state: nxt==tgt -> DONE, else -> WAIT with frame counter cleared.
- DONE: done<=1 (registered, one cycle), then return to IDLE.
- Latency:
  - Ramp: duty_we for step k is asserted exactly 2 cycles after the (div+1)-th qualifying frame_tick of that step.
  - Jump: duty_we is asserted at T+2.
  - done is asserted 1 cycle after the final duty_we.
- abort:
  - In WAIT or STEP: return to IDLE next cycle. No write in that cycle (abort beats a STEP write). No done pulse. cur keeps the last written value.
  - In IDLE or DONE: ignored; a DONE cycle still produces done.
- A command can be accepted in the same cycle the FSM returns to IDLE. New fades start from cur, not from 0.
- rst asserted mid-fade: all state clears at that edge, duty_out=0, no strobe. Software re-issues the command.
- duty_we and done are never high in the same cycle.

Test Plan:
1. Reset, then cmd target=40 step=10 div=0 with ticks every 256 cycles -> duty_we with duty_out 10, 20, 30, 40 on successive frames; done 1 cycle after the 40 write; busy low afterwards.
2. From cur=40, cmd target=0 step=15 div=1 -> writes 25, 10, 0 every 2nd tick (saturates at 0, no wrap); exactly 3 duty_we pulses.
3. cmd target=200 step=0 at cycle T -> single duty_we at T+2 with duty_out=200; done at T+3; no frame_tick needed.
4. cmd target=cur (200) step=5 -> no duty_we; done pulse at T+2; cmd_ready high at T+3.
5. From 0, target=250 step=100 div=0; assert abort in the cycle of the 2nd qualifying tick -> only the write of 100 occurs; duty_out stays 100; no done; next cmd accepted.
6. Assert rst mid-WAIT while cur=100 -> next cycle duty_out=0, busy=0, cmd_ready=1 once rst drops; frame_tick pulses during rst cause no writes.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for pwm8: ramps duty toward a commanded target,
// one step per (div+1) PWM frames, with instant jump, abort and done pulse.
module pwm_fade_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] cmd_step,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] duty_out,
    output logic             duty_we,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_stp;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             r_we;
    logic             r_done;
    logic             r_busy;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_nxt;
    logic             w_accept;

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign duty_out  = r_cur;
    assign duty_we   = r_we;
    assign busy      = r_busy;
    assign done      = r_done;

    // Next duty value: one step toward the target, clamped so it never overshoots or wraps
    always_comb begin
        w_sum  = {1'b0, r_cur} + {1'b0, r_stp};
        w_diff = {1'b0, r_cur} - {1'b0, r_stp};
        w_nxt  = r_tgt;
        if (r_stp == {WIDTH{1'b0}}) begin
            w_nxt = r_tgt;
        end else if (r_cur < r_tgt) begin
            if (w_sum > {1'b0, r_tgt}) begin
                w_nxt = r_tgt;
            end else begin
                w_nxt = w_sum[WIDTH-1:0];
            end
        end else if (r_cur > r_tgt) begin
            if (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < r_tgt)) begin
                w_nxt = r_tgt;
            end else begin
                w_nxt = w_diff[WIDTH-1:0];
            end
        end else begin
            w_nxt = r_tgt;
        end
    end

    // Next-state and frame-counter logic; the counter is zero whenever WAIT is (re)entered
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {DIV_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_target == r_cur) begin
                        w_state_nxt = S_DONE;
                    end else if (cmd_step == {WIDTH{1'b0}}) begin
                        w_state_nxt = S_STEP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (frame_tick && (r_cnt == r_div)) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_state_nxt = S_WAIT;
                    if (frame_tick) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
            end
            S_STEP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_nxt == r_tgt) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, command latch and registered outputs; abort in STEP suppresses the write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= {WIDTH{1'b0}};
            r_tgt   <= {WIDTH{1'b0}};
            r_stp   <= {WIDTH{1'b0}};
            r_div   <= {DIV_W{1'b0}};
            r_cnt   <= {DIV_W{1'b0}};
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_DONE);
            if (w_accept) begin
                r_tgt <= cmd_target;
                r_stp <= cmd_step;
                r_div <= cmd_div;
            end else begin
                r_tgt <= r_tgt;
                r_stp <= r_stp;
                r_div <= r_div;
            end
            if ((r_state == S_STEP) && !abort) begin
                r_cur <= w_nxt;
                r_we  <= 1'b1;
            end else begin
                r_cur <= r_cur;
                r_we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl: ramps, saturation, jump,
// no-op command, abort and mid-fade reset.
module tb_pwm_fade_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_div;
    logic       abort;
    logic [7:0] duty_out;
    logic       duty_we;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_fail;
    int cyc;
    int both_hi;
    logic [7:0] we_vals[$];
    int         we_cycs[$];
    int         done_cycs[$];
    int         tick_cycs[$];

    pwm_fade_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .duty_out   (duty_out),
        .duty_we    (duty_we),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, settle, and log strobes seen in the new cycle
    task automatic cyc1();
        @(posedge clk);
        #1;
        cyc++;
        if (duty_we) begin
            we_vals.push_back(duty_out);
            we_cycs.push_back(cyc);
        end
        if (done) done_cycs.push_back(cyc);
        if (duty_we && done) both_hi++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc1();
    endtask

    // n frames of given period; the tick is in the last cycle of each frame
    task automatic frames(input int n, input int period);
        for (int f = 0; f < n; f++) begin
            run(period - 1);
            frame_tick = 1'b1;
            tick_cycs.push_back(cyc);
            cyc1();
            frame_tick = 1'b0;
        end
    endtask

    task automatic clear_logs();
        we_vals.delete();
        we_cycs.delete();
        done_cycs.delete();
        tick_cycs.delete();
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [7:0] d,
                        output int tcyc);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        cmd_div    = d;
        tcyc       = cyc;
        cyc1();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(3);
        n_cmp++; if (duty_out !== 8'd0) begin n_fail++; $display("FAIL reset_duty got=%0d exp=0", duty_out); end
        n_cmp++; if (duty_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", duty_we); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rst got=%b exp=1", cmd_ready); end
        run(2);
    endtask

    task automatic test_ramp_up();
        int t;
        logic [7:0] exp[4];
        exp = '{8'd10, 8'd20, 8'd30, 8'd40};
        clear_logs();
        send(8'd40, 8'd10, 8'd0, t);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy got=%b exp=1", busy); end
        frames(4, 256);
        run(6);
        n_cmp++; if (we_vals.size() !== 4) begin n_fail++; $display("FAIL up_we_count got=%0d exp=4", we_vals.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= we_vals.size() || we_vals[k] !== exp[k] || we_cycs[k] !== tick_cycs[k] + 2) begin
                n_fail++;
                $display("FAIL up_write%0d got=%0d@%0d exp=%0d@%0d", k,
                         (k < we_vals.size()) ? we_vals[k] : 8'd0,
                         (k < we_cycs.size()) ? we_cycs[k] : -1, exp[k], tick_cycs[k] + 2);
            end
        end
        n_cmp++;
        if (done_cycs.size() !== 1 || we_cycs.size() !== 4 || done_cycs[0] !== we_cycs[3] + 1) begin
            n_fail++;
            $display("FAIL up_done ndone=%0d exp 1 cycle after last write", done_cycs.size());
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_ramp_down_div();
        int t;
        logic [7:0] exp[3];
        exp = '{8'd25, 8'd10, 8'd0};
        clear_logs();
        send(8'd0, 8'd15, 8'd1, t);
        frames(7, 20);
        run(4);
        n_cmp++; if (we_vals.size() !== 3) begin n_fail++; $display("FAIL down_we_count got=%0d exp=3", we_vals.size()); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (k >= we_vals.size() || we_vals[k] !== exp[k] || we_cycs[k] !== tick_cycs[2*k+1] + 2) begin
                n_fail++;
                $display("FAIL down_write%0d got=%0d exp=%0d@%0d", k,
                         (k < we_vals.size()) ? we_vals[k] : 8'd0, exp[k], tick_cycs[2*k+1] + 2);
            end
        end
        n_cmp++; if (done_cycs.size() !== 1) begin n_fail++; $display("FAIL down_done got=%0d exp=1", done_cycs.size()); end
    endtask

    task automatic test_jump();
        int t;
        clear_logs();
        send(8'd200, 8'd0, 8'd0, t);
        run(6);
        n_cmp++;
        if (we_cycs.size() !== 1 || we_cycs[0] !== t + 2 || we_vals[0] !== 8'd200) begin
            n_fail++; $display("FAIL jump_write n=%0d exp single 200 at T+2", we_cycs.size());
        end
        n_cmp++;
        if (done_cycs.size() !== 1 || done_cycs[0] !== t + 3) begin
            n_fail++; $display("FAIL jump_done n=%0d exp one at T+3", done_cycs.size());
        end
    endtask

    task automatic test_same_target();
        int t;
        clear_logs();
        send(8'd200, 8'd5, 8'd0, t);
        run(2);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready_T3 got=%b exp=1", cmd_ready); end
        run(3);
        n_cmp++; if (we_vals.size() !== 0) begin n_fail++; $display("FAIL same_no_write got=%0d exp=0", we_vals.size()); end
        n_cmp++;
        if (done_cycs.size() !== 1 || done_cycs[0] !== t + 2) begin
            n_fail++; $display("FAIL same_done n=%0d exp one at T+2", done_cycs.size());
        end
    endtask

    task automatic test_saturate();
        int t;
        send(8'd250, 8'd0, 8'd0, t);
        run(4);
        clear_logs();
        send(8'd255, 8'd10, 8'd0, t);
        frames(2, 20);
        run(3);
        n_cmp++;
        if (we_vals.size() !== 1 || we_vals[0] !== 8'd255) begin
            n_fail++; $display("FAIL sat_up n=%0d exp single write of 255", we_vals.size());
        end
        n_cmp++; if (duty_out !== 8'd255) begin n_fail++; $display("FAIL sat_duty got=%0d exp=255", duty_out); end
    endtask

    task automatic test_abort();
        int t;
        send(8'd0, 8'd0, 8'd0, t);
        run(4);
        clear_logs();
        send(8'd250, 8'd100, 8'd0, t);
        frames(1, 20);
        run(19);
        frame_tick = 1'b1;
        abort      = 1'b1;
        cyc1();
        frame_tick = 1'b0;
        abort      = 1'b0;
        frames(3, 20);
        n_cmp++;
        if (we_vals.size() !== 1 || we_vals[0] !== 8'd100) begin
            n_fail++; $display("FAIL abort_writes n=%0d exp single write of 100", we_vals.size());
        end
        n_cmp++; if (duty_out !== 8'd100) begin n_fail++; $display("FAIL abort_duty got=%0d exp=100", duty_out); end
        n_cmp++; if (done_cycs.size() !== 0) begin n_fail++; $display("FAIL abort_done got=%0d exp=0", done_cycs.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        send(8'd100, 8'd3, 8'd0, t);
        run(3);
        n_cmp++;
        if (done_cycs.size() !== 1 || done_cycs[0] !== t + 2) begin
            n_fail++; $display("FAIL abort_next_cmd n=%0d exp done at T+2", done_cycs.size());
        end
    endtask

    task automatic test_reset_mid_fade();
        int t;
        clear_logs();
        send(8'd200, 8'd10, 8'd3, t);
        frames(1, 20);
        run(3);
        rst = 1'b1;
        cyc1();
        n_cmp++; if (duty_out !== 8'd0) begin n_fail++; $display("FAIL midrst_duty got=%0d exp=0", duty_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", cmd_ready); end
        frame_tick = 1'b1;
        run(2);
        frame_tick = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after got=%b exp=1", cmd_ready); end
        frames(5, 20);
        n_cmp++; if (we_vals.size() !== 0) begin n_fail++; $display("FAIL midrst_no_write got=%0d exp=0", we_vals.size()); end
        n_cmp++; if (duty_out !== 8'd0) begin n_fail++; $display("FAIL midrst_duty_hold got=%0d exp=0", duty_out); end
        send(8'd77, 8'd0, 8'd0, t);
        run(3);
        n_cmp++;
        if (we_vals.size() !== 1 || we_vals[0] !== 8'd77 || duty_out !== 8'd77) begin
            n_fail++; $display("FAIL midrst_reissue n=%0d duty=%0d exp single write of 77", we_vals.size(), duty_out);
        end
        n_cmp++; if (both_hi !== 0) begin n_fail++; $display("FAIL we_done_overlap got=%0d exp=0", both_hi); end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        cyc        = 0;
        both_hi    = 0;
        rst        = 1'b1;
        frame_tick = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = 8'd0;
        cmd_step   = 8'd0;
        cmd_div    = 8'd0;
        abort      = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down_div();
        test_jump();
        test_same_target();
        test_saturate();
        test_abort();
        test_reset_mid_fade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
